// File: rtl/fwd_pkg.sv
// Shared definitions for the E-stage forwarding source pipeline: select codes,
// NOP/link constants, instruction classes and the shared class decoder hctrl.
package fwd_pkg;

    localparam logic [1:0]  FWD_SEL_RF  = 2'd0;
    localparam logic [1:0]  FWD_SEL_M   = 2'd1;
    localparam logic [1:0]  FWD_SEL_W   = 2'd2;
    localparam logic [31:0] NOP         = 32'h0000_0000;
    localparam logic [4:0]  LINK_REG    = 5'd31;
    localparam logic [31:0] LINK_OFFSET = 32'd8;

    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_CAL_R = 3'd1,
        CLS_CAL_I = 3'd2,
        CLS_LOAD  = 3'd3,
        CLS_JAL   = 3'd4
    } instr_class_e;

    typedef enum logic [1:0] {
        RES_ALU  = 2'd0,
        RES_MEM  = 2'd1,
        RES_LINK = 2'd2
    } res_src_e;

    // MIPS-style opcode/funct classification into writeback classes
    function automatic instr_class_e hctrl(input logic [31:0] instr);
        instr_class_e cls;
        cls = CLS_NONE;
        case (instr[31:26])
            6'h00: begin
                case (instr[5:0])
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2a, 6'h2b: cls = CLS_CAL_R;
                    default:                    cls = CLS_NONE;
                endcase
            end
            6'h08, 6'h09, 6'h0a, 6'h0b,
            6'h0c, 6'h0d, 6'h0e, 6'h0f:          cls = CLS_CAL_I;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25:   cls = CLS_LOAD;
            6'h03:                               cls = CLS_JAL;
            default:                             cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/fwd_dest_decode.sv
// Destination decoder: maps an instruction to its register-file write enable,
// destination register and the source of its result (alu/mem/link).
module fwd_dest_decode
    import fwd_pkg::*;
(
    input  logic [31:0] instr,
    output logic        we,
    output logic [4:0]  dest,
    output res_src_e    src
);

    instr_class_e cls_s;

    assign cls_s = hctrl(instr);

    // Destination and result source per class; writes to $0 are suppressed
    always_comb begin
        dest = 5'd0;
        src  = RES_ALU;
        case (cls_s)
            CLS_CAL_R: dest = instr[15:11];
            CLS_CAL_I: dest = instr[20:16];
            CLS_LOAD: begin
                dest = instr[20:16];
                src  = RES_MEM;
            end
            CLS_JAL: begin
                dest = LINK_REG;
                src  = RES_LINK;
            end
            default: begin
                dest = 5'd0;
                src  = RES_ALU;
            end
        endcase
        if ((cls_s != CLS_NONE) && (dest != 5'd0)) begin
            we = 1'b1;
        end else begin
            we = 1'b0;
        end
    end

endmodule

// File: rtl/fwd_source_pipe.sv
// E->M->W producer pipeline for operand forwarding and the register-file write
// port. Optional bubble counter enabled by defining FWD_PERF_CNT_EN.
module fwd_source_pipe
    import fwd_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] instrD,
    input  logic [31:0] pcD,
    input  logic [31:0] aluoutE,
    input  logic [31:0] dmem_rdataM,
    output logic [31:0] instrE,
    output logic [31:0] instrM,
    output logic [31:0] instrW,
    output logic [31:0] pcE,
    output logic [31:0] fwd_dataM,
    output logic [31:0] fwd_dataW,
    output logic        rf_weW,
    output logic [4:0]  rf_waddrW,
    output logic [31:0] rf_wdataW
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0] bubble_cnt
`endif
);

    logic [31:0] instr_e_r, pc_e_r;
    logic [31:0] instr_m_r, pc_m_r, aluout_m_r;
    logic [31:0] instr_w_r, pc_w_r, aluout_w_r, memdata_w_r;

    logic        we_m_s, we_w_s;
    logic [4:0]  dest_m_s, dest_w_s;
    res_src_e    src_m_s, src_w_s;
    logic [31:0] fwd_data_m_s, fwd_data_w_s;
    logic        unused_m_s;

    // Stage registers; a stall replaces E with a bubble while M and W keep moving
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_e_r   <= NOP;
            pc_e_r      <= RESET_PC;
            instr_m_r   <= NOP;
            pc_m_r      <= RESET_PC;
            aluout_m_r  <= 32'h0000_0000;
            instr_w_r   <= NOP;
            pc_w_r      <= RESET_PC;
            aluout_w_r  <= 32'h0000_0000;
            memdata_w_r <= 32'h0000_0000;
        end else begin
            instr_w_r   <= instr_m_r;
            pc_w_r      <= pc_m_r;
            aluout_w_r  <= aluout_m_r;
            memdata_w_r <= dmem_rdataM;
            instr_m_r   <= instr_e_r;
            pc_m_r      <= pc_e_r;
            aluout_m_r  <= aluoutE;
            if (stall) begin
                instr_e_r <= NOP;
            end else begin
                instr_e_r <= instrD;
                pc_e_r    <= pcD;
            end
        end
    end

    fwd_dest_decode u_dec_m (
        .instr (instr_m_r),
        .we    (we_m_s),
        .dest  (dest_m_s),
        .src   (src_m_s)
    );

    fwd_dest_decode u_dec_w (
        .instr (instr_w_r),
        .we    (we_w_s),
        .dest  (dest_w_s),
        .src   (src_w_s)
    );

    // Only the result source matters in M; a load there is never forwarded
    assign unused_m_s = ^{we_m_s, dest_m_s};

    // M-stage forward value: link address for jal, otherwise the ALU result
    always_comb begin
        fwd_data_m_s = aluout_m_r;
        if (src_m_s == RES_LINK) begin
            fwd_data_m_s = pc_m_r + LINK_OFFSET;
        end else begin
            fwd_data_m_s = aluout_m_r;
        end
    end

    // W-stage result: also the register-file write data
    always_comb begin
        fwd_data_w_s = aluout_w_r;
        case (src_w_s)
            RES_LINK: fwd_data_w_s = pc_w_r + LINK_OFFSET;
            RES_MEM:  fwd_data_w_s = memdata_w_r;
            default:  fwd_data_w_s = aluout_w_r;
        endcase
    end

    assign instrE    = instr_e_r;
    assign instrM    = instr_m_r;
    assign instrW    = instr_w_r;
    assign pcE       = pc_e_r;
    assign fwd_dataM = fwd_data_m_s;
    assign fwd_dataW = fwd_data_w_s;
    assign rf_wdataW = fwd_data_w_s;
    assign rf_weW    = we_w_s;
    assign rf_waddrW = dest_w_s;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] bubble_cnt_r;

    // Saturating count of bubbles inserted into E
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_r <= 32'h0000_0000;
        end else if (stall && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
            bubble_cnt_r <= bubble_cnt_r + 32'd1;
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_fwd_source_pipe.sv
// Self-checking bench for fwd_source_pipe: directed scenarios plus a randomized
// run against a stage-level reference model. Define FWD_PERF_CNT_EN to cover bubble_cnt.
module tb_fwd_source_pipe;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic [31:0] instrD, pcD, aluoutE, dmem_rdataM;
    logic [31:0] instrE, instrM, instrW, pcE, fwd_dataM, fwd_dataW, rf_wdataW;
    logic        rf_weW;
    logic [4:0]  rf_waddrW;
`ifdef FWD_PERF_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: what each stage holds
    logic [31:0] m_e_instr, m_e_pc;
    logic [31:0] m_m_instr, m_m_pc, m_m_alu;
    logic [31:0] m_w_instr, m_w_pc, m_w_alu, m_w_mem;
    logic [31:0] m_cnt;

    fwd_source_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .instrD      (instrD),
        .pcD         (pcD),
        .aluoutE     (aluoutE),
        .dmem_rdataM (dmem_rdataM),
        .instrE      (instrE),
        .instrM      (instrM),
        .instrW      (instrW),
        .pcE         (pcE),
        .fwd_dataM   (fwd_dataM),
        .fwd_dataW   (fwd_dataW),
        .rf_weW      (rf_weW),
        .rf_waddrW   (rf_waddrW),
        .rf_wdataW   (rf_wdataW)
`ifdef FWD_PERF_CNT_EN
        ,
        .bubble_cnt  (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // 0 none, 1 register ALU, 2 immediate ALU, 3 load, 4 jal (bench's instruction subset)
    function automatic int classify(input logic [31:0] ins);
        int c;
        c = 0;
        if (ins[31:26] == 6'h00 && (ins[5:0] == 6'h21 || ins[5:0] == 6'h23)) c = 1;
        else if (ins[31:26] == 6'h0d || ins[31:26] == 6'h09) c = 2;
        else if (ins[31:26] == 6'h23) c = 3;
        else if (ins[31:26] == 6'h03) c = 4;
        return c;
    endfunction

    function automatic logic [4:0] dest_of(input logic [31:0] ins);
        int c;
        c = classify(ins);
        if (c == 1) return ins[15:11];
        if (c == 2 || c == 3) return ins[20:16];
        if (c == 4) return 5'd31;
        return 5'd0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] a, b, d;
        a = 5'($urandom); b = 5'($urandom); d = 5'($urandom);
        case ($urandom_range(0, 8))
            0: return enc_r(a, b, d, 6'h21);
            1: return enc_r(a, b, d, 6'h23);
            2: return enc_i(6'h0d, a, b, 16'($urandom));
            3: return enc_i(6'h09, a, b, 16'($urandom));
            4: return enc_i(6'h23, a, b, 16'($urandom));
            5: return enc_i(6'h2b, a, b, 16'($urandom));
            6: return enc_i(6'h04, a, b, 16'($urandom));
            7: return {6'h03, 26'($urandom)};
            default: return 32'h0000_0000;
        endcase
    endfunction

    // drive one cycle of inputs, clock it, advance the model, settle at negedge
    task automatic tick(input logic rst, input logic stl, input logic [31:0] ins, pc, alu, mem);
        reset = rst; stall = stl; instrD = ins; pcD = pc; aluoutE = alu; dmem_rdataM = mem;
        @(posedge clk);
        if (rst) begin
            {m_e_instr, m_m_instr, m_w_instr} = '0;
            m_e_pc = 32'h3000; m_m_pc = 32'h3000; m_w_pc = 32'h3000;
            m_m_alu = 32'h0; m_w_alu = 32'h0; m_w_mem = 32'h0; m_cnt = 32'h0;
        end else begin
            m_w_instr = m_m_instr; m_w_pc = m_m_pc; m_w_alu = m_m_alu; m_w_mem = mem;
            m_m_instr = m_e_instr; m_m_pc = m_e_pc; m_m_alu = alu;
            if (stl) m_e_instr = 32'h0;
            else begin m_e_instr = ins; m_e_pc = pc; end
            if (stl && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 32'h3000, 32'h0, 32'h0);
        n_checks++;
        if (rf_weW !== 1'b0 || rf_waddrW !== 5'd0) begin
            n_fail++; $display("FAIL reset_rf: we=%0b waddr=%0d, expected 0/0", rf_weW, rf_waddrW);
        end
        n_checks++;
        if ({instrE, instrM, instrW} !== 96'h0) begin
            n_fail++; $display("FAIL reset_instr: E=%h M=%h W=%h, expected 0", instrE, instrM, instrW);
        end
        n_checks++;
        if (pcE !== 32'h3000) begin
            n_fail++; $display("FAIL reset_pcE: got %h expected 00003000", pcE);
        end
`ifdef FWD_PERF_CNT_EN
        n_checks++;
        if (bubble_cnt !== 32'h0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d expected 0", bubble_cnt);
        end
`endif
    endtask

    task automatic test_alu();
        logic [31:0] addu3;
        addu3 = enc_r(5'd1, 5'd2, 5'd3, 6'h21);
        tick(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, addu3, 32'h3004, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 32'h3008, 32'd5, 32'h0);
        n_checks++;
        if (fwd_dataM !== 32'd5 || instrM !== addu3) begin
            n_fail++; $display("FAIL alu_fwdM: got %h (instrM %h) expected 5", fwd_dataM, instrM);
        end
        tick(1'b0, 1'b0, 32'h0, 32'h300c, 32'h77, 32'h99);
        n_checks++;
        if (fwd_dataW !== 32'd5 || rf_weW !== 1'b1 || rf_waddrW !== 5'd3 || rf_wdataW !== 32'd5) begin
            n_fail++; $display("FAIL alu_W: data=%h we=%0b waddr=%0d expected 5/1/3", fwd_dataW, rf_weW, rf_waddrW);
        end
    endtask

    task automatic test_jal(input logic [31:0] pc, input logic [31:0] link);
        tick(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, {6'h03, 26'h0000C40}, pc, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 32'h0, 32'h1234, 32'h0);
        n_checks++;
        if (fwd_dataM !== link) begin
            n_fail++; $display("FAIL jal_fwdM: got %h expected %h", fwd_dataM, link);
        end
        tick(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h5555);
        n_checks++;
        if (rf_waddrW !== 5'd31 || rf_wdataW !== link || rf_weW !== 1'b1) begin
            n_fail++; $display("FAIL jal_W: waddr=%0d wdata=%h we=%0b expected 31/%h/1", rf_waddrW, rf_wdataW, rf_weW, link);
        end
    endtask

    task automatic test_load();
        tick(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, enc_i(6'h23, 5'd1, 5'd4, 16'h10), 32'h3020, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 32'h3024, 32'h0000_1010, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 32'h3028, 32'h0, 32'hDEAD_BEEF);
        n_checks++;
        if (fwd_dataW !== 32'hDEAD_BEEF || rf_waddrW !== 5'd4 || rf_weW !== 1'b1) begin
            n_fail++; $display("FAIL load_W: data=%h waddr=%0d we=%0b expected deadbeef/4/1", fwd_dataW, rf_waddrW, rf_weW);
        end
    endtask

    task automatic test_stall();
        logic [31:0] ori5, nxt;
        ori5 = enc_i(6'h0d, 5'd0, 5'd5, 16'h0007);
        nxt  = enc_r(5'd5, 5'd5, 5'd6, 6'h21);
        tick(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, ori5, 32'h3100, 32'h0, 32'h0);
        tick(1'b0, 1'b1, nxt, 32'h3104, 32'h7, 32'h0);
        n_checks++;
        if (instrE !== 32'h0 || instrM !== ori5) begin
            n_fail++; $display("FAIL stall_bubble1: E=%h M=%h expected 0/%h", instrE, instrM, ori5);
        end
        tick(1'b0, 1'b1, nxt, 32'h3104, 32'h0, 32'h0);
        n_checks++;
        if (instrE !== 32'h0 || instrW !== ori5 || rf_waddrW !== 5'd5 || fwd_dataW !== 32'h7 || pcE !== 32'h3100) begin
            n_fail++; $display("FAIL stall_bubble2: E=%h W=%h waddr=%0d data=%h pcE=%h", instrE, instrW, rf_waddrW, fwd_dataW, pcE);
        end
`ifdef FWD_PERF_CNT_EN
        n_checks++;
        if (bubble_cnt !== 32'd2) begin
            n_fail++; $display("FAIL stall_cnt: got %0d expected 2", bubble_cnt);
        end
`endif
        tick(1'b0, 1'b0, nxt, 32'h3104, 32'h0, 32'h0);
        n_checks++;
        if (instrE !== nxt || pcE !== 32'h3104) begin
            n_fail++; $display("FAIL stall_release: E=%h pcE=%h expected %h/00003104", instrE, pcE, nxt);
        end
    endtask

    task automatic test_zero_dest_and_reset();
        tick(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, enc_i(6'h0d, 5'd0, 5'd0, 16'h0007), 32'h3200, 32'h0, 32'h0);
        tick(1'b0, 1'b0, enc_r(5'd1, 5'd2, 5'd7, 6'h21), 32'h3204, 32'h7, 32'h0);
        tick(1'b0, 1'b0, enc_i(6'h09, 5'd1, 5'd8, 16'h1), 32'h3208, 32'h9, 32'h0);
        n_checks++;
        if (rf_weW !== 1'b0 || rf_waddrW !== 5'd0 || rf_wdataW !== 32'h7) begin
            n_fail++; $display("FAIL zero_dest: we=%0b waddr=%0d wdata=%h expected 0/0/7", rf_weW, rf_waddrW, rf_wdataW);
        end
        tick(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h3210, 32'hA, 32'hB);
        n_checks++;
        if ({instrE, instrM, instrW} !== 96'h0 || pcE !== 32'h3000 || rf_weW !== 1'b0 || fwd_dataM !== 32'h0 || fwd_dataW !== 32'h0) begin
            n_fail++; $display("FAIL midreset: E=%h M=%h W=%h pcE=%h we=%0b", instrE, instrM, instrW, pcE, rf_weW);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_m, exp_w;
        logic        exp_we;
        int          cm, cw;
        tick(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 99) < 3), ($urandom_range(0, 3) == 0), rand_instr(),
                 ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : $urandom, $urandom, $urandom);
            cm = classify(m_m_instr);
            cw = classify(m_w_instr);
            exp_m  = (cm == 4) ? m_m_pc + 32'd8 : m_m_alu;
            exp_w  = (cw == 4) ? m_w_pc + 32'd8 : (cw == 3) ? m_w_mem : m_w_alu;
            exp_we = (cw != 0) && (dest_of(m_w_instr) != 5'd0);
            n_checks++;
            if (instrE !== m_e_instr || pcE !== m_e_pc || instrM !== m_m_instr || instrW !== m_w_instr) begin
                n_fail++; $display("FAIL rnd_stages[%0d]: E=%h/%h M=%h W=%h expected %h/%h %h %h",
                                   i, instrE, pcE, instrM, instrW, m_e_instr, m_e_pc, m_m_instr, m_w_instr);
            end
            n_checks++;
            if (fwd_dataM !== exp_m) begin
                n_fail++; $display("FAIL rnd_fwdM[%0d]: got %h expected %h", i, fwd_dataM, exp_m);
            end
            n_checks++;
            if (fwd_dataW !== exp_w || rf_wdataW !== exp_w) begin
                n_fail++; $display("FAIL rnd_fwdW[%0d]: got %h/%h expected %h", i, fwd_dataW, rf_wdataW, exp_w);
            end
            n_checks++;
            if (rf_weW !== exp_we || rf_waddrW !== dest_of(m_w_instr)) begin
                n_fail++; $display("FAIL rnd_rf[%0d]: we=%0b waddr=%0d expected %0b/%0d",
                                   i, rf_weW, rf_waddrW, exp_we, dest_of(m_w_instr));
            end
`ifdef FWD_PERF_CNT_EN
            n_checks++;
            if (bubble_cnt !== m_cnt) begin
                n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", i, bubble_cnt, m_cnt);
            end
`endif
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; instrD = 32'h0; pcD = 32'h0; aluoutE = 32'h0; dmem_rdataM = 32'h0;
        @(negedge clk);
        test_reset();
        test_alu();
        test_jal(32'h0000_3010, 32'h0000_3018);
        test_jal(32'hFFFF_FFFC, 32'h0000_0004);
        test_load();
        test_stall();
        test_zero_dest_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
